// File: rtl/lifo_stack_param_if.sv
// Handshake bundle for lifo_stack_param: push/pop requests from the master side,
// popped data, occupancy and status flags back from the stack.
interface lifo_stack_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [DATA_W-1:0] top_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, top_data, count, full, empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, top_data, count, full, empty, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO: registered pop data with a valid strobe, combinational
// top-of-stack peek, replace-top on simultaneous push/pop and bypass when empty.
module lifo_stack_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                clock,
  input  logic                reset,
  lifo_stack_param_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [CW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] pop_data_reg, pop_data_next;
  logic              pop_valid_reg, pop_valid_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic              is_empty, is_full;
  logic [AW-1:0]     top_idx;
  logic [DATA_W-1:0] top_word;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == FULL_C);
  // top_idx is only meaningful when the stack is non-empty; top_word is masked otherwise.
  assign top_idx  = AW'(count_reg - ONE);
  assign top_word = is_empty ? '0 : mem_reg[top_idx];

  always_comb begin
    count_next     = count_reg;
    pop_data_next  = pop_data_reg;
    pop_valid_next = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = top_idx;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          overflow_next = 1'b1;
        end else begin
          wr_en      = 1'b1;
          wr_idx     = AW'(count_reg);
          count_next = count_reg + ONE;
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_next = 1'b1;
        end else begin
          pop_data_next  = top_word;
          pop_valid_next = 1'b1;
          count_next     = count_reg - ONE;
        end
      end
      2'b11: begin
        pop_valid_next = 1'b1;
        if (is_empty) begin
          // Bypass: the pushed word goes straight to pop_data, nothing is stored.
          pop_data_next = bus.push_data;
        end else begin
          pop_data_next = top_word;
          wr_en         = 1'b1;
          wr_idx        = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Storage is deliberately not reset; count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem_reg[wr_idx] <= bus.push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg     <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      pop_data_reg  <= pop_data_next;
      pop_valid_reg <= pop_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.pop_data    = pop_data_reg;
  assign bus.pop_valid   = pop_valid_reg;
  assign bus.top_data    = top_word;
  assign bus.count       = count_reg;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almost_full = (count_reg >= AFULL_C);
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param (DEPTH=4, DATA_W=8): a queue-based stack model
// predicts flags, and popped words are scoreboarded until the DUT strobes pop_valid.
module tb_lifo_stack_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AFULL  = DEPTH - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] model[$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] last_pop;
  logic              exp_valid, exp_ovf, exp_unf;

  lifo_stack_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lifo_stack_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, update the model, sample 1 time unit after posedge.
  task automatic step(input logic rst, input logic ph, input logic [DATA_W-1:0] d, input logic pp);
    int n;
    logic [DATA_W-1:0] exp_top;
    @(negedge clock);
    reset = rst;
    bus.push = ph;
    bus.push_data = d;
    bus.pop = pp;
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (rst) begin
      model.delete();
      sb.delete();
      last_pop = '0;
    end else if (ph && pp) begin
      exp_valid = 1'b1;
      if (model.size() == 0) begin
        last_pop = d;
      end else begin
        last_pop = model[$];
        model[$] = d;
      end
      sb.push_back(last_pop);
    end else if (ph) begin
      if (model.size() == DEPTH) exp_ovf = 1'b1;
      else model.push_back(d);
    end else if (pp) begin
      if (model.size() == 0) begin
        exp_unf = 1'b1;
      end else begin
        last_pop = model.pop_back();
        exp_valid = 1'b1;
        sb.push_back(last_pop);
      end
    end
    @(posedge clock);
    #1;
    n = model.size();
    exp_top = (n > 0) ? model[n-1] : '0;
    chk("count", 32'(bus.count), 32'(n));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AFULL));
    chk("top_data", 32'(bus.top_data), 32'(exp_top));
    chk("pop_valid", 32'(bus.pop_valid), 32'(exp_valid));
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("underflow", 32'(bus.underflow), 32'(exp_unf));
    chk("pop_data_hold", 32'(bus.pop_data), 32'(last_pop));
    if (bus.pop_valid === 1'b1) begin
      if (sb.size() > 0) chk("sb_pop_data", 32'(bus.pop_data), 32'(sb.pop_front()));
      else chk("sb_unexpected_valid", 32'(bus.pop_valid), 32'(0));
    end
    $display("step rst=%0b push=%0b pop=%0b d=%02h -> count=%0d top=%02h pop_data=%02h pv=%0b ovf=%0b unf=%0b",
             rst, ph, pp, d, bus.count, bus.top_data, bus.pop_data, bus.pop_valid,
             bus.overflow, bus.underflow);
  endtask

  initial begin
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.pop = 1'b0;
    last_pop = '0;
    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Fill to full
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b0);
    chk("plan_top_44", 32'(bus.top_data), 32'h44);
    chk("plan_full", 32'(bus.full), 32'h1);
    // Overflow, then drain
    step(1'b0, 1'b1, 8'h55, 1'b0);
    chk("plan_ovf_top", 32'(bus.top_data), 32'h44);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("plan_pop_44", 32'(bus.pop_data), 32'h44);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("plan_pop_11", 32'(bus.pop_data), 32'h11);
    // Underflow, then bypass
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("plan_unf_hold", 32'(bus.pop_data), 32'h11);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("plan_bypass", 32'(bus.pop_data), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Replace-top on partial stack
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h09, 1'b1);
    chk("plan_replace_old", 32'(bus.pop_data), 32'h02);
    chk("plan_replace_top", 32'(bus.top_data), 32'h09);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("plan_pop_09", 32'(bus.pop_data), 32'h09);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    // Replace-top on full stack
    step(1'b0, 1'b1, 8'hA1, 1'b0);
    step(1'b0, 1'b1, 8'hB2, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    step(1'b0, 1'b1, 8'hD4, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    chk("plan_full_replace", 32'(bus.pop_data), 32'hD4);
    // Reset with push pending on a 3-entry stack
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("plan_rst_count", 32'(bus.count), 32'h0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    chk("plan_top_3c", 32'(bus.top_data), 32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
